// File: rtl/pn_pkg.sv
// pn_pkg: shared PN address-field constants, grant encoding and command helpers
package pn_pkg;
  localparam int PARAM_BIT = 14;
  localparam logic [1:0] TGT_SYN = 2'b01;
  localparam logic [1:0] TGT_SOMA = 2'b10;
  localparam logic [1:0] TGT_STDP = 2'b11;
  localparam int SPK_W = 14;
  localparam int SPK_DEPTH = 8;
  localparam int STARVE_LIMIT = 4;
  typedef enum logic [1:0] {GNT_NONE, GNT_SWU, GNT_CFG, GNT_SPK} gnt_e;
  function automatic logic [15:0] swu_iaddr(input logic [6:0] a);
    return {1'b0, 1'b1, TGT_SYN, 5'b0, a};
  endfunction
endpackage

// File: rtl/pn_spike_fifo.sv
// pn_spike_fifo: spike event queue, no bypass, synchronous flush
// Ports: clk, rst (async active-low), push/din write, pop/dout read of the head,
//        flush empties the queue, count is current occupancy.
module pn_spike_fifo
  import pn_pkg::*;
#(
  parameter int W = SPK_W,
  parameter int D = SPK_DEPTH,
  localparam int AW = $clog2(D),
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/pn_ingress_arbiter.sv
// pn_ingress_arbiter: merges CFG writes, STDP updates and queued spikes into one PN command stream
// Ports: clk, rst (async active-low); cfg_* / swu_* / spk_* valid-ready sources;
//        spk_flush clears the spike queue; iADDR/W_DATA/SWU_EN/SWU_Addr/SWU_DATA +
//        cmd_valid form the registered command; spk_count occupancy; cfg_addr_err sticky.
module pn_ingress_arbiter
  import pn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [15:0] cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        spk_valid,
  output logic        spk_ready,
  input  logic [13:0] spk_addr,
  input  logic        swu_valid,
  output logic        swu_ready,
  input  logic [6:0]  swu_addr,
  input  logic [7:0]  swu_data,
  input  logic        spk_flush,
  output logic [15:0] iADDR,
  output logic [31:0] W_DATA,
  output logic        SWU_EN,
  output logic [6:0]  SWU_Addr,
  output logic [7:0]  SWU_DATA,
  output logic        cmd_valid,
  output logic [3:0]  spk_count,
  output logic        cfg_addr_err
);
  logic [SPK_W-1:0] spk_head;
  logic [2:0] starve_cnt, starve_nxt;
  logic spk_elig, starve_hit, spk_push, spk_pop, cfg_ok;
  gnt_e gnt;
  logic cmd_valid_nxt, swu_en_nxt;
  logic [15:0] iaddr_nxt;
  logic [31:0] wdata_nxt;
  logic [6:0] swu_addr_nxt;
  logic [7:0] swu_data_nxt;
  pn_spike_fifo u_fifo (
    .clk(clk),
    .rst(rst),
    .push(spk_push),
    .pop(spk_pop),
    .flush(spk_flush),
    .din(spk_addr),
    .dout(spk_head),
    .count(spk_count)
  );
  assign spk_elig = (spk_count != 4'd0) && !spk_flush;
  assign starve_hit = spk_elig && (starve_cnt == 3'(STARVE_LIMIT));
  assign cfg_ok = cfg_addr[PARAM_BIT];
  // Starvation overrides the fixed SWU > CFG > SPIKE order; nothing is granted in reset.
  always_comb
    gnt = !rst ? GNT_NONE : starve_hit ? GNT_SPK : swu_valid ? GNT_SWU :
          cfg_valid ? GNT_CFG : spk_elig ? GNT_SPK : GNT_NONE;
  assign swu_ready = gnt == GNT_SWU;
  assign cfg_ready = gnt == GNT_CFG;
  // A flushing cycle refuses new spikes so an accepted spike is never silently lost.
  assign spk_ready = rst && (spk_count != 4'(SPK_DEPTH)) && !spk_flush;
  assign spk_push = spk_valid && spk_ready;
  assign spk_pop = gnt == GNT_SPK;
  always_comb begin
    cmd_valid_nxt = (gnt == GNT_SWU) || (gnt == GNT_SPK) || (gnt == GNT_CFG && cfg_ok);
    iaddr_nxt = gnt == GNT_SWU ? swu_iaddr(swu_addr) :
                (gnt == GNT_CFG && cfg_ok) ? cfg_addr :
                gnt == GNT_SPK ? {2'b00, spk_head} : 16'h0;
    wdata_nxt = (gnt == GNT_CFG && cfg_ok) ? cfg_data : 32'h0;
    swu_en_nxt = gnt == GNT_SWU;
    swu_addr_nxt = gnt == GNT_SWU ? swu_addr : 7'h0;
    swu_data_nxt = gnt == GNT_SWU ? swu_data : 8'h0;
    starve_nxt = (spk_flush || spk_count == 4'd0 || gnt == GNT_SPK) ? 3'd0 :
                 gnt != GNT_NONE ? starve_cnt + 3'd1 : starve_cnt;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cmd_valid <= 1'b0;
      iADDR <= '0;
      W_DATA <= '0;
      SWU_EN <= 1'b0;
      SWU_Addr <= '0;
      SWU_DATA <= '0;
      starve_cnt <= '0;
      cfg_addr_err <= 1'b0;
    end else begin
      cmd_valid <= cmd_valid_nxt;
      iADDR <= iaddr_nxt;
      W_DATA <= wdata_nxt;
      SWU_EN <= swu_en_nxt;
      SWU_Addr <= swu_addr_nxt;
      SWU_DATA <= swu_data_nxt;
      starve_cnt <= starve_nxt;
      cfg_addr_err <= cfg_addr_err || (gnt == GNT_CFG && !cfg_ok);
    end
endmodule

// File: tb/tb_pn_ingress_arbiter.sv
// tb_pn_ingress_arbiter: randomized + directed bench against a queue-based reference model
module tb_pn_ingress_arbiter;
  logic clk = 0, rst = 0;
  logic cfg_valid = 0, spk_valid = 0, swu_valid = 0, spk_flush = 0;
  logic [15:0] cfg_addr = 0;
  logic [31:0] cfg_data = 0;
  logic [13:0] spk_addr = 0;
  logic [6:0] swu_addr = 0;
  logic [7:0] swu_data = 0;
  logic cfg_ready, spk_ready, swu_ready, SWU_EN, cmd_valid, cfg_addr_err;
  logic [15:0] iADDR;
  logic [31:0] W_DATA;
  logic [6:0] SWU_Addr;
  logic [7:0] SWU_DATA;
  logic [3:0] spk_count;
  int checks = 0, errors = 0, n_spk = 0, n_cfg = 0;
  logic [13:0] q[$];
  int st = 0;
  bit err = 0;
  bit e_cv = 0, e_se = 0;
  logic [15:0] e_ia = 0;
  logic [31:0] e_wd = 0;
  logic [6:0] e_sa = 0;
  logic [7:0] e_sd = 0;
  always #5 clk = ~clk;
  pn_ingress_arbiter dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_addr(spk_addr),
    .swu_valid(swu_valid), .swu_ready(swu_ready), .swu_addr(swu_addr), .swu_data(swu_data),
    .spk_flush(spk_flush),
    .iADDR(iADDR), .W_DATA(W_DATA), .SWU_EN(SWU_EN), .SWU_Addr(SWU_Addr), .SWU_DATA(SWU_DATA),
    .cmd_valid(cmd_valid), .spk_count(spk_count), .cfg_addr_err(cfg_addr_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    st = 0;
    err = 0;
    {e_cv, e_se, e_ia, e_wd, e_sa, e_sd} = '0;
  endtask
  task automatic cycle(input bit sv, input logic [6:0] sa, input logic [7:0] sd,
                       input bit cv, input logic [15:0] ca, input logic [31:0] cd,
                       input bit pv, input logic [13:0] pa, input bit fl);
    int sz, g;
    bit elig, sr;
    @(negedge clk);
    swu_valid = sv; swu_addr = sa; swu_data = sd;
    cfg_valid = cv; cfg_addr = ca; cfg_data = cd;
    spk_valid = pv; spk_addr = pa; spk_flush = fl;
    #1;
    if (cmd_valid) begin
      if (iADDR[15:14] == 2'b00) n_spk++;
      else n_cfg++;
    end
    check("cmd_valid", cmd_valid, e_cv);
    check("iADDR", iADDR, e_ia);
    check("W_DATA", W_DATA, e_wd);
    check("SWU_EN", SWU_EN, e_se);
    check("SWU_Addr", SWU_Addr, e_sa);
    check("SWU_DATA", SWU_DATA, e_sd);
    check("spk_count", spk_count, q.size());
    check("cfg_addr_err", cfg_addr_err, err);
    sz = q.size();
    elig = sz > 0 && !fl;
    g = (elig && st == 4) ? 3 : sv ? 1 : cv ? 2 : elig ? 3 : 0;
    sr = sz < 8 && !fl;
    check("swu_ready", swu_ready, g == 1);
    check("cfg_ready", cfg_ready, g == 2);
    check("spk_ready", spk_ready, sr);
    {e_cv, e_se, e_ia, e_wd, e_sa, e_sd} = '0;
    if (g == 1) begin
      e_cv = 1; e_se = 1; e_ia = 16'h5000 | 16'(sa); e_sa = sa; e_sd = sd;
    end else if (g == 2) begin
      if (ca[14]) begin e_cv = 1; e_ia = ca; e_wd = cd; end
      else err = 1;
    end else if (g == 3) begin
      e_cv = 1; e_ia = {2'b00, q.pop_front()};
    end
    if (fl || sz == 0 || g == 3) st = 0;
    else if (g != 0) st++;
    if (fl) q.delete();
    else if (pv && sr) q.push_back(pa);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    int i;
    #1;
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_iADDR", iADDR, 0);
    check("rst_spk_ready", spk_ready, 0);
    check("rst_spk_count", spk_count, 0);
    check("rst_cfg_err", cfg_addr_err, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    model_reset();
    idle(2);
    cycle(0, 0, 0, 1, 16'h5003, 32'hAA, 0, 0, 0);
    @(posedge clk); #1;
    check("r25_iaddr", iADDR, 16'h5003);
    check("r25_wdata", W_DATA, 32'hAA);
    check("r25_valid", cmd_valid, 1);
    check("r25_swu_en", SWU_EN, 0);
    cycle(1, 7'h12, 8'h7F, 1, 16'h5003, 32'hAA, 0, 0, 0);
    @(posedge clk); #1;
    check("r26_swu_iaddr", iADDR, 16'h5012);
    check("r26_swu_en", SWU_EN, 1);
    cycle(0, 0, 0, 1, 16'h5003, 32'hAA, 0, 0, 0);
    @(posedge clk); #1;
    check("r26_cfg_iaddr", iADDR, 16'h5003);
    idle(2);
    i = 0;
    while (q.size() < 8 && i < 30) begin
      cycle(1, 7'h05, 8'h11, 0, 0, 0, 1, 14'h0100 + 14'(i), 0);
      i++;
    end
    check("r27_bound", i < 30, 1);
    @(posedge clk); #1;
    check("r27_full_count", spk_count, 8);
    check("r27_full_ready", spk_ready, 0);
    idle(12);
    cycle(0, 0, 0, 1, 16'h1003, 32'h55, 0, 0, 0);
    @(posedge clk); #1;
    check("r29_no_cmd", cmd_valid, 0);
    check("r29_err", cfg_addr_err, 1);
    idle(2);
    for (int k = 0; k < 6; k++) cycle(1, 7'h22, 8'h33, 0, 0, 0, 1, 14'h0200 + 14'(k), 0);
    @(posedge clk); #1;
    check("r29_queued5", spk_count, 5);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    check("r29_flush_count", spk_count, 0);
    check("r29_flush_nocmd", cmd_valid, 0);
    check("r29_err_sticky", cfg_addr_err, 1);
    idle(3);
    n_spk = 0; n_cfg = 0;
    for (int k = 0; k < 16; k++)
      cycle(0, 0, 0, 1, 16'h4000 + 16'(k), 32'(k), k < 3, 14'h02A0 + 14'(k), 0);
    idle(1);
    check("r28_spikes", n_spk, 3);
    check("r28_cfgs", n_cfg, 13);
    idle(2);
    for (int k = 0; k < 3; k++) cycle(1, 7'h01, 8'h02, 0, 0, 0, 1, 14'h0300 + 14'(k), 0);
    cycle(1, 7'h03, 8'h04, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("r30_pre_cmd", cmd_valid, 1);
    check("r30_pre_count", spk_count, 3);
    #2 rst = 0;
    #1;
    check("r30_cmd_valid", cmd_valid, 0);
    check("r30_iADDR", iADDR, 0);
    check("r30_SWU_EN", SWU_EN, 0);
    check("r30_SWU_Addr", SWU_Addr, 0);
    check("r30_count", spk_count, 0);
    check("r30_swu_ready", swu_ready, 0);
    check("r30_cfg_err", cfg_addr_err, 0);
    {swu_valid, cfg_valid, spk_valid, spk_flush} = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
    idle(1);
    check("r30_after_count", spk_count, 0);
    for (int k = 0; k < 1500; k++)
      cycle($urandom_range(0, 3) == 0, 7'($urandom), 8'($urandom),
            $urandom_range(0, 2) != 0, 16'($urandom), $urandom,
            $urandom_range(0, 1) == 1, 14'($urandom), $urandom_range(0, 30) == 0);
    idle(12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
